// File: rtl/div_unit_radix_pkg.sv
// Shared definitions for the radix-2^B iterative divider.
// Latency: n/a (types, encodings and helper function only).
// Backpressure: n/a.
package div_unit_radix_pkg;

    // div_op encodings as seen on the request port
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CALC   = 2'b01,
        ST_FINISH = 2'b10
    } div_state_e;

    // Wide enough for XLEN=64 with one bit per cycle (64 iterations)
    localparam int CNT_W = 7;

    // Number of CALC cycles: W-forms on RV64 only divide 32 bits
    function automatic int unsigned iter_count(input int unsigned xlen,
                                               input int unsigned bpc,
                                               input logic        word);
        return ((word && (xlen == 64)) ? 32 : xlen) / bpc;
    endfunction

endpackage

// File: rtl/div_unit_radix_if.sv
// Request/response bundle between the EX-stage sequencer and the divider.
// Latency: n/a (wiring only).
// Backpressure: none; requester must watch busy, start while busy is dropped.
// Ports: start/kill/div_op/is_word_op/dividend/divisor toward the divider,
//        result/busy/ready back to the requester.
interface div_unit_radix_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    logic [1:0]      div_op;
    logic            is_word_op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] result;
    logic            busy;
    logic            ready;

    modport master (
        output start, kill, div_op, is_word_op, dividend, divisor,
        input  result, busy, ready
    );

    modport slave (
        input  start, kill, div_op, is_word_op, dividend, divisor,
        output result, busy, ready
    );
endinterface

// File: rtl/div_unit_radix_step_comb.sv
// B cascaded restoring-division steps, MSB-first quotient bits.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_rem/i_quo/i_div current partial remainder, quotient/dividend
//        shift register and divisor; o_rem/o_quo values after B steps.
module div_unit_radix_step_comb #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic [XLEN:0]   i_rem,
    input  logic [XLEN-1:0] i_div,
    input  logic [XLEN-1:0] i_quo,
    output logic [XLEN:0]   o_rem,
    output logic [XLEN-1:0] o_quo
);
    logic [XLEN:0]   w_rem [BITS_PER_CYCLE+1];
    logic [XLEN-1:0] w_quo [BITS_PER_CYCLE+1];

    assign w_rem[0] = i_rem;
    assign w_quo[0] = i_quo;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        logic [XLEN:0] w_sh;
        logic [XLEN:0] w_diff;
        logic          w_ge;

        // The quotient register still holds the unconsumed dividend bits in
        // its upper end; shift the next one into the partial remainder.
        assign w_sh   = {w_rem[g][XLEN-1:0], w_quo[g][XLEN-1]};
        assign w_diff = w_sh - {1'b0, i_div};
        // A set carry bit means the shifted value already exceeds any divisor.
        assign w_ge   = w_rem[g][XLEN] | (w_sh >= {1'b0, i_div});

        assign w_rem[g+1] = w_ge ? w_diff : w_sh;
        assign w_quo[g+1] = {w_quo[g][XLEN-2:0], w_ge};
    end

    assign o_rem = w_rem[BITS_PER_CYCLE];
    assign o_quo = w_quo[BITS_PER_CYCLE];
endmodule

// File: rtl/div_unit_radix.sv
// Iterative integer divider (DIV/DIVU/REM/REMU and RV64 W-forms), B quotient bits per clock.
// Latency: N+2 cycles start->ready (N = width/B); 1 cycle on divide-by-zero/overflow/small fast paths.
// Backpressure: busy high while iterating; start while busy is ignored, kill aborts silently.
// Ports: clk, reset (async active-high), bus (slave side of div_unit_radix_if).
module div_unit_radix #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 2,
    parameter int FAST_PATH      = 1
) (
    input  logic              clk,
    input  logic              reset,
    div_unit_radix_if.slave   bus
);
    import div_unit_radix_pkg::*;

    localparam logic [XLEN-1:0] ALL_ONES = '1;

    // Sign-extend bit 31 across the upper half for W-form results
    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x,
                                               input logic            word);
        logic [XLEN-1:0] y;
        y = x;
        if (word) begin
            for (int i = 32; i < XLEN; i++) y[i] = x[31];
        end
        return y;
    endfunction

    div_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN:0]   r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;
    logic            r_neg;
    logic            r_is_rem;
    logic            r_word;
    logic [XLEN-1:0] r_result;
    logic            r_ready;

    logic            w_word, w_signed, w_is_rem;
    logic [XLEN-1:0] w_a_ext, w_b_ext, w_abs_a, w_abs_b, w_min;
    logic            w_sa, w_sb, w_div0, w_ovf, w_small, w_fast, w_neg;
    logic [XLEN-1:0] w_fast_res, w_quo_init;
    logic [CNT_W-1:0] w_cnt_init;
    logic [XLEN:0]   w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;
    logic [XLEN-1:0] w_mag, w_signed_res, w_final;

    // ---------------- operand preparation ----------------
    assign w_word   = (XLEN == 64) && bus.is_word_op;
    assign w_signed = (bus.div_op == OP_DIV) || (bus.div_op == OP_REM);
    assign w_is_rem = (bus.div_op == OP_REM) || (bus.div_op == OP_REMU);

    always_comb begin
        w_a_ext = bus.dividend;
        w_b_ext = bus.divisor;
        if (w_word) begin
            for (int i = 32; i < XLEN; i++) begin
                w_a_ext[i] = w_signed & bus.dividend[31];
                w_b_ext[i] = w_signed & bus.divisor[31];
            end
        end
    end

    assign w_sa    = w_signed & w_a_ext[XLEN-1];
    assign w_sb    = w_signed & w_b_ext[XLEN-1];
    // |MIN| wraps to MIN, which read as unsigned is the correct magnitude
    assign w_abs_a = w_sa ? -w_a_ext : w_a_ext;
    assign w_abs_b = w_sb ? -w_b_ext : w_b_ext;

    // MIN of the effective width, in its extended XLEN form
    assign w_min   = w_word ? (ALL_ONES << 31) : (ALL_ONES << (XLEN-1));
    assign w_div0  = (w_b_ext == '0);
    assign w_ovf   = w_signed && (w_a_ext == w_min) && (w_b_ext == ALL_ONES);
    assign w_small = (w_abs_a < w_abs_b);
    assign w_fast  = (FAST_PATH != 0) && (w_div0 || w_ovf || w_small);

    // Quotient sign is forced positive on divide-by-zero so the iterative
    // path also yields all-ones when the fast path is disabled.
    assign w_neg   = w_is_rem ? w_sa : ((w_sa ^ w_sb) & ~w_div0);

    always_comb begin
        w_fast_res = '0;
        if (w_div0)      w_fast_res = w_is_rem ? w_a_ext : ALL_ONES;
        else if (w_ovf)  w_fast_res = w_is_rem ? '0      : w_a_ext;
        else             w_fast_res = w_is_rem ? w_a_ext : '0;
        w_fast_res = sext_w(w_fast_res, w_word);
    end

    // W-forms start with the 32-bit magnitude at the top so the MSB-first
    // steps consume it; after 32 steps the quotient sits in the low half.
    assign w_quo_init = w_word ? (w_abs_a << 32) : w_abs_a;
    assign w_cnt_init = CNT_W'(iter_count(XLEN, BITS_PER_CYCLE, w_word));

    // ---------------- iteration datapath ----------------
    div_unit_radix_step_comb #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .i_rem (r_rem),
        .i_div (r_div),
        .i_quo (r_quo),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    // ---------------- finalization ----------------
    assign w_mag        = r_is_rem ? r_rem[XLEN-1:0] : r_quo;
    assign w_signed_res = r_neg ? -w_mag : w_mag;
    assign w_final      = sext_w(w_signed_res, r_word);

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_neg    <= 1'b0;
            r_is_rem <= 1'b0;
            r_word   <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start && !bus.kill) begin
                        if (w_fast) begin
                            r_result <= w_fast_res;
                            r_ready  <= 1'b1;
                        end else begin
                            r_rem    <= '0;
                            r_quo    <= w_quo_init;
                            r_div    <= w_abs_b;
                            r_cnt    <= w_cnt_init;
                            r_neg    <= w_neg;
                            r_is_rem <= w_is_rem;
                            r_word   <= w_word;
                            r_state  <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (bus.kill) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) r_state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                    if (!bus.kill) begin
                        r_result <= w_final;
                        r_ready  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.result = r_result;
    assign bus.ready  = r_ready;
    assign bus.busy   = (r_state != ST_IDLE);
endmodule
